iq_tx_serializer: RTL and testbench

- Read-side consumer of the complex I/Q sample FIFO on the TX path.
- Pops one 32-bit I/Q word per 16 clocks and builds a 32-bit radio frame: {2'b10, I[12:0], 1'b0, 2'b01, Q[12:0], 1'b0}.
- Shifts the frame out MSB-first, 2 bits per clock, into an external DDR output cell that feeds the transceiver LVDS TX lane.
- Runs entirely in the FIFO read clock domain.

---
 rtl/iq_tx_pkg.sv | 29 ++
 rtl/iq_tx_serializer.sv | 128 ++++++++++++
 tb/tb_iq_tx_serializer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iq_tx_pkg.sv
// Shared definitions for the TX I/Q serializer: frame layout constants, FSM states, frame packer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package iq_tx_pkg;

    localparam int          FRAME_BITS   = 32;
    localparam int          BITS_PER_CLK = 2;
    localparam int          FIELD_BITS   = 13;
    localparam logic [1:0]  I_SYNC       = 2'b10;
    localparam logic [1:0]  Q_SYNC       = 2'b01;
    localparam logic [3:0]  PHASE_POP    = 4'd14;
    localparam logic [3:0]  PHASE_LAST   = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFETCH = 2'd1,
        ST_LOAD     = 2'd2,
        ST_STREAM   = 2'd3
    } state_t;

    // Radio frame: sync pair, 13-bit sample, guard zero; I half first, Q half second.
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic [FIELD_BITS-1:0] i_smp,
        input logic [FIELD_BITS-1:0] q_smp
    );
        return {I_SYNC, i_smp, 1'b0, Q_SYNC, q_smp, 1'b0};
    endfunction

endpackage

// File: rtl/iq_tx_serializer.sv
// Pops one I/Q word per 16 clocks from the TX sample FIFO and shifts a 32-bit frame out 2 bits/clk.
// Latency: tx_en_i sampled at edge n -> first bit pair on data_o after edge n+2 (pop, load, stream).
// Backpressure: none downstream; an empty FIFO at the pop slot yields an all-zero frame and counts an underrun.
module iq_tx_serializer
    import iq_tx_pkg::*;
#(
    parameter int SAMPLE_BITS = 13,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 rd_clk_i,
    input  logic                 rd_rst_b_i,
    input  logic                 tx_en_i,
    input  logic                 clr_underrun_i,
    output logic                 rd_en_o,
    input  logic [31:0]          rd_data_i,
    input  logic                 empty_i,
    output logic [1:0]           data_o,
    output logic                 busy_o,
    output logic                 frame_start_o,
    output logic                 underrun_o,
    output logic [CNT_WIDTH-1:0] underrun_cnt_o
);

    // Only the low SAMPLE_BITS of each 16-bit half carry sample data.
    localparam logic [FIELD_BITS-1:0] SMP_MASK = FIELD_BITS'((32'd1 << SAMPLE_BITS) - 32'd1);

    state_t                 r_state;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [3:0]             r_phase;
    logic                   r_pop;
    logic                   r_en_lat;
    logic                   r_underrun;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic                   w_rd_en;
    logic                   w_underrun;
    logic [FIELD_BITS-1:0]  w_i_smp;
    logic [FIELD_BITS-1:0]  w_q_smp;
    logic [FRAME_BITS-1:0]  w_frame;
    logic                   w_unused_bits;

    assign w_i_smp       = rd_data_i[16 +: FIELD_BITS] & SMP_MASK;
    assign w_q_smp       = rd_data_i[0  +: FIELD_BITS] & SMP_MASK;
    assign w_frame       = pack_frame(w_i_smp, w_q_smp);
    assign w_unused_bits = ^{rd_data_i[31:16+FIELD_BITS], rd_data_i[15:FIELD_BITS]};

    // Pop once to prime the pipeline, then only in the phase-14 slot and only when data is there.
    assign w_rd_en = (r_state == ST_PREFETCH) |
                     ((r_state == ST_STREAM) & (r_phase == PHASE_POP) & tx_en_i & ~empty_i);

    // Underrun: frame boundary reached, streaming was still requested, but nothing was popped.
    assign w_underrun = (r_state == ST_STREAM) & (r_phase == PHASE_LAST) & ~r_pop & r_en_lat;

    assign rd_en_o        = w_rd_en;
    assign data_o         = r_shift[FRAME_BITS-1 -: BITS_PER_CLK];
    assign busy_o         = (r_state != ST_IDLE);
    assign frame_start_o  = (r_state == ST_STREAM) & (r_phase == 4'd0);
    assign underrun_o     = r_underrun;
    assign underrun_cnt_o = r_cnt;

    // Serializer FSM, shifter, phase counter and sticky underrun accounting.
    always_ff @(posedge rd_clk_i) begin
        if (!rd_rst_b_i) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_phase    <= '0;
            r_pop      <= 1'b0;
            r_en_lat   <= 1'b0;
            r_underrun <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_shift <= '0;
                    r_phase <= '0;
                    if (tx_en_i && !empty_i) begin
                        r_state <= ST_PREFETCH;
                    end
                end
                ST_PREFETCH: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_shift <= w_frame;
                    r_phase <= '0;
                    r_state <= ST_STREAM;
                end
                ST_STREAM: begin
                    // The pop/underrun/stop decision is frozen in the pop slot so late
                    // changes of tx_en_i or empty_i cannot disturb the frame boundary.
                    if (r_phase == PHASE_POP) begin
                        r_pop    <= w_rd_en;
                        r_en_lat <= tx_en_i;
                    end
                    if (r_phase == PHASE_LAST) begin
                        r_phase <= '0;
                        if (r_pop) begin
                            r_shift <= w_frame;
                        end else begin
                            r_shift <= '0;
                            if (!r_en_lat) begin
                                r_state <= ST_IDLE;
                            end
                        end
                    end else begin
                        r_shift <= r_shift << BITS_PER_CLK;
                        r_phase <= r_phase + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Clear has priority over a coincident underrun for both flag and counter.
            if (clr_underrun_i) begin
                r_underrun <= 1'b0;
                r_cnt      <= '0;
            end else if (w_underrun) begin
                r_underrun <= 1'b1;
                if (r_cnt != {CNT_WIDTH{1'b1}}) begin
                    r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: tb/tb_iq_tx_serializer.sv
// Self-checking bench for iq_tx_serializer: FIFO model, frame scoreboard, latency and corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_iq_tx_serializer;

    logic        rd_clk_i = 1'b0;
    logic        rd_rst_b_i;
    logic        tx_en_i;
    logic        clr_underrun_i;
    logic        rd_en_o;
    logic [31:0] rd_data_i;
    logic        empty_i;
    logic [1:0]  data_o;
    logic        busy_o;
    logic        frame_start_o;
    logic        underrun_o;
    logic [15:0] underrun_cnt_o;

    iq_tx_serializer #(.SAMPLE_BITS(13), .CNT_WIDTH(16)) dut (
        .rd_clk_i       (rd_clk_i),
        .rd_rst_b_i     (rd_rst_b_i),
        .tx_en_i        (tx_en_i),
        .clr_underrun_i (clr_underrun_i),
        .rd_en_o        (rd_en_o),
        .rd_data_i      (rd_data_i),
        .empty_i        (empty_i),
        .data_o         (data_o),
        .busy_o         (busy_o),
        .frame_start_o  (frame_start_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o)
    );

    always #5 rd_clk_i = ~rd_clk_i;

    typedef struct {
        logic [31:0] word;
        logic [31:0] frame;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] fifo[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_frames = 0;
    logic [31:0] col_word = '0;
    int          col_cnt  = 0;
    bit          collecting = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: sample pop request, advance the FIFO model after the edge, return at the negedge.
    task automatic tick();
        logic pop_now;
        #1;
        pop_now = rd_en_o;
        if (pop_now === 1'b1) chk("pop_while_empty", {31'd0, empty_i}, 32'd0);
        @(posedge rd_clk_i);
        #1;
        if (pop_now === 1'b1 && fifo.size() > 0) rd_data_i = fifo.pop_front();
        empty_i = (fifo.size() == 0);
        @(negedge rd_clk_i);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push(input logic [31:0] w);
        fifo.push_back(w);
        empty_i = 1'b0;
    endtask

    task automatic wait_fs(input string name);
        int k;
        k = 0;
        while (frame_start_o !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk(name, {31'd0, frame_start_o}, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy_o !== 1'b0 && k < 100) begin
            tick();
            k++;
        end
        chk(name, {31'd0, busy_o}, 32'd0);
    endtask

    // Frame collector: assembles 16 pairs starting at frame_start_o and scores them.
    always @(negedge rd_clk_i) begin
        if (frame_start_o === 1'b1) begin
            col_word   = {30'd0, data_o};
            col_cnt    = 1;
            collecting = 1'b1;
        end else if (collecting) begin
            if (busy_o !== 1'b1) begin
                collecting = 1'b0;
            end else begin
                col_word = {col_word[29:0], data_o};
                col_cnt++;
            end
        end
        if (collecting && col_cnt == 16) begin
            collecting = 1'b0;
            n_frames++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL frame_unexpected: got %h, expected no frame", col_word);
            end else begin
                chk($sformatf("frame%0d", n_frames), col_word, exp_q.pop_front());
            end
        end
    end

    initial begin
        tbl[0] = '{32'h0ABC_1234, 32'h9578_6468};
        tbl[1] = '{32'h1555_0AAA, 32'hAAAA_5554};
        tbl[2] = '{32'h0000_1FFF, 32'h8000_7FFE};
        tbl[3] = '{32'hFFFF_FFFF, 32'hBFFE_7FFE};
        tbl[4] = '{32'hE000_E000, 32'h8000_4000};
        tbl[5] = '{32'h1FFF_0000, 32'hBFFE_4000};

        rd_rst_b_i     = 1'b0;
        tx_en_i        = 1'b0;
        clr_underrun_i = 1'b0;
        rd_data_i      = '0;
        empty_i        = 1'b1;
        @(negedge rd_clk_i);
        ticks(3);

        // Reset state
        chk("rst_data",      {30'd0, data_o},        32'd0);
        chk("rst_busy",      {31'd0, busy_o},        32'd0);
        chk("rst_fstart",    {31'd0, frame_start_o}, 32'd0);
        chk("rst_underrun",  {31'd0, underrun_o},    32'd0);
        chk("rst_cnt",       {16'd0, underrun_cnt_o}, 32'd0);
        chk("rst_rd_en",     {31'd0, rd_en_o},       32'd0);
        rd_rst_b_i = 1'b1;
        tick();

        // Single word, 3-cycle latency, tx_en dropped at phase 3
        push(32'h0ABC_1234);
        exp_q.push_back(32'h9578_6468);
        tx_en_i = 1'b1;
        tick();
        chk("lat_prefetch_rd_en", {31'd0, rd_en_o}, 32'd1);
        chk("lat_prefetch_busy",  {31'd0, busy_o},  32'd1);
        tick();
        chk("lat_load_rd_en",     {31'd0, rd_en_o}, 32'd0);
        chk("lat_load_data",      {30'd0, data_o},  32'd0);
        tick();
        chk("lat_first_pair",     {30'd0, data_o},  32'd2);
        chk("lat_fstart",         {31'd0, frame_start_o}, 32'd1);
        push(32'h1555_0AAA);
        ticks(3);
        tx_en_i = 1'b0;
        ticks(11);
        chk("drop_no_pop_ph14",   {31'd0, rd_en_o}, 32'd0);
        tick();
        chk("drop_busy_ph15",     {31'd0, busy_o},  32'd1);
        tick();
        chk("drop_busy_after",    {31'd0, busy_o},  32'd0);
        chk("drop_data_after",    {30'd0, data_o},  32'd0);
        ticks(3);
        chk("drop_stays_idle",    {31'd0, busy_o | rd_en_o}, 32'd0);
        fifo.delete();
        empty_i = 1'b1;

        // Table of words streamed back to back, then underruns, refill, clear
        for (int i = 0; i < 6; i++) begin
            push(tbl[i].word);
            exp_q.push_back(tbl[i].frame);
        end
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        tx_en_i = 1'b1;
        wait_fs("stream_start");
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("seamless_f%0d", i), {31'd0, frame_start_o}, 32'd1);
            for (int p = 1; p < 16; p++) begin
                tick();
                chk($sformatf("rd_en_f%0d_p%0d", i, p), {31'd0, rd_en_o},
                    {31'd0, (p == 14 && i < 5)});
            end
            tick();
        end
        chk("ur1_fstart",   {31'd0, frame_start_o}, 32'd1);
        chk("ur1_flag",     {31'd0, underrun_o},    32'd1);
        chk("ur1_cnt",      {16'd0, underrun_cnt_o}, 32'd1);
        ticks(14);
        chk("ur1_no_pop",   {31'd0, rd_en_o},       32'd0);
        ticks(2);
        chk("ur2_fstart",   {31'd0, frame_start_o}, 32'd1);
        chk("ur2_cnt",      {16'd0, underrun_cnt_o}, 32'd2);
        push(32'h1FFF_0000);
        exp_q.push_back(32'hBFFE_4000);
        ticks(14);
        chk("refill_pop",   {31'd0, rd_en_o},       32'd1);
        ticks(2);
        chk("refill_fstart", {31'd0, frame_start_o}, 32'd1);
        chk("refill_cnt",   {16'd0, underrun_cnt_o}, 32'd2);
        tx_en_i        = 1'b0;
        clr_underrun_i = 1'b1;
        tick();
        clr_underrun_i = 1'b0;
        chk("clr_flag",     {31'd0, underrun_o},    32'd0);
        chk("clr_cnt",      {16'd0, underrun_cnt_o}, 32'd0);
        wait_idle("refill_end_idle");

        // Reset in the middle of a frame
        push(32'h0ABC_1234);
        exp_q.push_back(32'h9578_6468);
        tx_en_i = 1'b1;
        wait_fs("midrst_start");
        ticks(7);
        rd_rst_b_i = 1'b0;
        tick();
        chk("midrst_data",   {30'd0, data_o},        32'd0);
        chk("midrst_busy",   {31'd0, busy_o},        32'd0);
        chk("midrst_cnt",    {16'd0, underrun_cnt_o}, 32'd0);
        chk("midrst_rd_en",  {31'd0, rd_en_o},       32'd0);
        chk("midrst_fstart", {31'd0, frame_start_o}, 32'd0);
        exp_q.delete();
        rd_rst_b_i = 1'b1;
        push(32'h0000_1FFF);
        exp_q.push_back(32'h8000_7FFE);
        tick();
        chk("restart_rd_en", {31'd0, rd_en_o},       32'd1);
        ticks(2);
        chk("restart_pair",  {30'd0, data_o},        32'd2);
        chk("restart_fstart", {31'd0, frame_start_o}, 32'd1);
        tx_en_i = 1'b0;
        wait_idle("restart_end_idle");

        // Enabled with an empty FIFO: must stay idle and count nothing
        tx_en_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            chk($sformatf("empty_idle_c%0d", k), {30'd0, busy_o, rd_en_o}, 32'd0);
        end
        chk("empty_idle_cnt",  {16'd0, underrun_cnt_o}, 32'd0);
        chk("empty_idle_flag", {31'd0, underrun_o},     32'd0);
        tx_en_i = 1'b0;
        ticks(2);

        chk("frames_seen",        n_frames,     32'd11);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
